// File: rtl/mem_port_arbiter.sv
// Single-bus arbiter between instruction fetch and data access ports.
// Data side has priority; one registered bus transaction outstanding at a time.
module mem_port_arbiter (
   input  logic        clk,
   input  logic        rst,
   // fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   // data port
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [3:0]  dm_sel,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   // external bus
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   // pipeline
   output logic        stall
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_IF_BUSY = 2'd1,
      S_DM_BUSY = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic            r_bus_req;
   logic            r_bus_we;
   logic [SW-1:0]   r_bus_sel;
   logic [AW-1:0]   r_bus_addr;
   logic [DW-1:0]   r_bus_wdata;
   logic            r_if_ready;
   logic            r_dm_ready;
   logic [DW-1:0]   r_if_rdata;
   logic [DW-1:0]   r_dm_rdata;

   logic            w_if_elig;
   logic            w_dm_elig;
   logic            w_grant_if;
   logic            w_grant_dm;
   logic            w_done_if;
   logic            w_done_dm;

   // A requester is masked in the cycle its ready pulse is high, so the
   // request it is still holding is not reissued.
   assign w_if_elig = if_req & ~r_if_ready;
   assign w_dm_elig = dm_req & ~r_dm_ready;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and grant/complete strobes
   always_comb begin
      w_state_nxt = r_state;
      w_grant_if  = 1'b0;
      w_grant_dm  = 1'b0;
      w_done_if   = 1'b0;
      w_done_dm   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_dm_elig) begin
               w_state_nxt = S_DM_BUSY;
               w_grant_dm  = 1'b1;
            end else if (w_if_elig) begin
               w_state_nxt = S_IF_BUSY;
               w_grant_if  = 1'b1;
            end
         end
         S_IF_BUSY: begin
            if (bus_ack) begin
               w_state_nxt = S_IDLE;
               w_done_if   = 1'b1;
            end
         end
         S_DM_BUSY: begin
            if (bus_ack) begin
               w_state_nxt = S_IDLE;
               w_done_dm   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Bus command, ready pulses and read-data capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_sel   <= '0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_if_ready  <= 1'b0;
         r_dm_ready  <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
      end else begin
         r_if_ready <= w_done_if;
         r_dm_ready <= w_done_dm;
         if (w_grant_dm) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= dm_we;
            r_bus_sel   <= dm_sel;
            r_bus_addr  <= dm_addr;
            r_bus_wdata <= dm_wdata;
         end else if (w_grant_if) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= SW'(4'hF);
            r_bus_addr  <= if_addr;
            r_bus_wdata <= '0;
         end else if (w_done_if || w_done_dm) begin
            r_bus_req   <= 1'b0;
         end
         if (w_done_if) begin
            r_if_rdata <= bus_rdata;
         end
         if (w_done_dm && !r_bus_we) begin
            r_dm_rdata <= bus_rdata;
         end
      end
   end

   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_sel   = r_bus_sel;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign if_ready  = r_if_ready;
   assign dm_ready  = r_dm_ready;
   assign if_rdata  = r_if_rdata;
   assign dm_rdata  = r_dm_rdata;

   // Stall while either stage has a request that has not yet completed
   assign stall = (if_req & ~r_if_ready) | (dm_req & ~r_dm_ready);

endmodule
